// File: rtl/float_pkg.sv
// Shared types and constants for the single-precision divider fixup stage.
package float_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fclass_t;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;

  // One alignment-pipeline entry: everything the output stage needs besides div_res.
  typedef struct packed {
    logic               valid;
    logic               sign;
    fclass_t            c1;
    fclass_t            c2;
    logic signed [9:0]  d;
    logic               lt;
  } pipe_t;

  // Denormals are flushed to zero, so any zero exponent classifies as ZERO.
  function automatic fclass_t classify(input logic [31:0] v);
    fclass_t c;
    if (v[30:23] == 8'h00)      c = ZERO;
    else if (v[30:23] == 8'hFF) c = (v[22:0] == '0) ? INF : NAN;
    else                        c = NORM;
    return c;
  endfunction

endpackage

// File: rtl/float_div_fixup_if.sv
// Operand/result bundle between the divider front end and the fixup stage.
// Optional sticky_flags signal present when FLOAT_DIV_FIXUP_STICKY_EN is defined.
interface float_div_fixup_if;
  logic        in_valid;
  logic [31:0] v1;
  logic [31:0] v2;
  logic [31:0] div_res;
  logic        clr_sticky;
  logic        out_valid;
  logic [31:0] res;
  logic        flag_invalid;
  logic        flag_divzero;
  logic        flag_overflow;
  logic        flag_underflow;
`ifdef FLOAT_DIV_FIXUP_STICKY_EN
  logic [3:0]  sticky_flags;
`endif

  modport master (
    output in_valid, v1, v2, div_res, clr_sticky,
    input  out_valid, res, flag_invalid, flag_divzero, flag_overflow, flag_underflow
`ifdef FLOAT_DIV_FIXUP_STICKY_EN
    , input sticky_flags
`endif
  );

  modport slave (
    input  in_valid, v1, v2, div_res, clr_sticky,
    output out_valid, res, flag_invalid, flag_divzero, flag_overflow, flag_underflow
`ifdef FLOAT_DIV_FIXUP_STICKY_EN
    , output sticky_flags
`endif
  );
endinterface

// File: rtl/float_classify.sv
// Combinational IEEE-754 single operand classifier (ZERO/NORM/INF/NAN, FTZ).
module float_classify
  import float_pkg::*;
(
  input  logic [31:0] v,
  output fclass_t     cls
);
  logic unused_sign;
  assign unused_sign = v[31];

  always_comb cls = classify(v);
endmodule

// File: rtl/float_div_fixup.sv
// Fixup stage aligned to the pipelined divider: special values, range, FTZ, flags.
// Optional sticky flag accumulator enabled by FLOAT_DIV_FIXUP_STICKY_EN.
module float_div_fixup
  import float_pkg::*;
#(
  parameter int unsigned DIV_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  float_div_fixup_if.slave bus
);

  localparam logic signed [9:0] BIAS10 = 10'(EXP_BIAS);
  localparam logic signed [9:0] EMAX10 = 10'(EXP_MAX);

  fclass_t c1, c2;
  float_classify u_cls1 (.v(bus.v1), .cls(c1));
  float_classify u_cls2 (.v(bus.v2), .cls(c2));

  pipe_t pipe_q [DIV_LAT];
  pipe_t pipe_d [DIV_LAT];
  pipe_t entry;
  pipe_t last;

  logic signed [9:0] e1, e2, b;
  logic        out_valid_q, out_valid_d;
  logic [31:0] res_q, res_d;
  logic [3:0]  flags_q, flags_d, raw_flags;

  logic unused_div_hi;
  assign unused_div_hi = &{1'b0, bus.div_res[31:23]};

  always_comb begin
    e1          = signed'({2'b00, bus.v1[30:23]});
    e2          = signed'({2'b00, bus.v2[30:23]});
    entry       = '0;
    entry.valid = bus.in_valid;
    entry.sign  = bus.v1[31] ^ bus.v2[31];
    entry.c1    = c1;
    entry.c2    = c2;
    entry.d     = e1 - e2 + BIAS10;
    entry.lt    = {1'b1, bus.v1[22:0]} < {1'b1, bus.v2[22:0]};
    pipe_d[0]   = entry;
    for (int unsigned i = 1; i < DIV_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  // Flag vector order is {invalid, divzero, overflow, underflow}.
  always_comb begin
    last      = pipe_q[DIV_LAT-1];
    b         = last.d - 10'(last.lt);
    res_d     = '0;
    raw_flags = '0;
    if (last.c1 == NAN || last.c2 == NAN ||
        (last.c1 == ZERO && last.c2 == ZERO) ||
        (last.c1 == INF  && last.c2 == INF)) begin
      res_d        = QNAN;
      raw_flags[3] = 1'b1;
    end else if (last.c1 == NORM && last.c2 == ZERO) begin
      res_d        = {last.sign, 8'hFF, 23'd0};
      raw_flags[2] = 1'b1;
    end else if (last.c1 == INF) begin
      res_d = {last.sign, 8'hFF, 23'd0};
    end else if (last.c1 == ZERO || last.c2 == INF) begin
      res_d = {last.sign, 31'd0};
    end else if (b >= EMAX10) begin
      res_d        = {last.sign, 8'hFF, 23'd0};
      raw_flags[1] = 1'b1;
    end else if (b <= 10'sd0) begin
      res_d        = {last.sign, 31'd0};
      raw_flags[0] = 1'b1;
    end else begin
      res_d = {last.sign, b[7:0], bus.div_res[22:0]};
    end
    out_valid_d = last.valid;
    flags_d     = last.valid ? raw_flags : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DIV_LAT; i++) pipe_q[i] <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      flags_q     <= '0;
    end else begin
      for (int unsigned i = 0; i < DIV_LAT; i++) pipe_q[i] <= pipe_d[i];
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.res            = res_q;
  assign bus.flag_invalid   = flags_q[3];
  assign bus.flag_divzero   = flags_q[2];
  assign bus.flag_overflow  = flags_q[1];
  assign bus.flag_underflow = flags_q[0];

`ifdef FLOAT_DIV_FIXUP_STICKY_EN
  logic [3:0] sticky_q, sticky_d;

  // Accumulates on the same edge the flags register loads, so a clear
  // coinciding with a new flag keeps only that flag.
  always_comb sticky_d = (bus.clr_sticky ? 4'b0000 : sticky_q) | flags_d;

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= '0;
    else     sticky_q <= sticky_d;
  end

  assign bus.sticky_flags = sticky_q;
`else
  logic unused_clr;
  assign unused_clr = bus.clr_sticky;
`endif

endmodule

// File: tb/tb_float_div_fixup.sv
// Directed table-driven bench for float_div_fixup with a latency-3 stand-in divider.
// Sticky flag checks are compiled when FLOAT_DIV_FIXUP_STICKY_EN is defined.
module tb_float_div_fixup;

  typedef struct {
    string       name;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] raw;
    logic [31:0] exp_res;
    logic [3:0]  exp_flags;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  float_div_fixup_if bus ();
  float_div_fixup #(.DIV_LAT(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Stand-in divider: raw result appears three edges after operand sample.
  logic [31:0] raw_in = '0;
  logic [31:0] dq [3];
  always @(posedge clk) begin
    dq[0] <= raw_in;
    dq[1] <= dq[0];
    dq[2] <= dq[1];
  end
  assign bus.div_res = dq[2];

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [31:0] a, logic [31:0] b,
                              logic [31:0] r, logic [31:0] e, logic [3:0] f);
    vec_t v;
    v.name = n; v.v1 = a; v.v2 = b; v.raw = r; v.exp_res = e; v.exp_flags = f;
    return v;
  endfunction

  function logic [3:0] flags_now();
    return {bus.flag_invalid, bus.flag_divzero, bus.flag_overflow, bus.flag_underflow};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r);
    bus.in_valid = v;
    bus.v1       = a;
    bus.v2       = b;
    raw_in       = r;
  endtask

  // Single isolated op: checks latency, result and flags.
  task automatic run_vec(input int i);
    int  lat;
    bit  got;
    got = 0;
    lat = 0;
    @(negedge clk);
    drive(1'b1, vecs[i].v1, vecs[i].v2, vecs[i].raw);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) drive(1'b0, '0, '0, '0);
      if (bus.out_valid) begin
        got = 1;
        lat = k + 1;
        break;
      end
    end
    check({vecs[i].name, " seen"}, 32'(got), 32'd1);
    if (got) begin
      check({vecs[i].name, " latency"}, 32'(lat), 32'd4);
      check({vecs[i].name, " res"}, bus.res, vecs[i].exp_res);
      check({vecs[i].name, " flags"}, 32'(flags_now()), 32'(vecs[i].exp_flags));
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sched_cyc [5] = '{0, 1, 2, 4, 5};
    int sched_op  [5] = '{0, 1, 3, 5, 2};
    int op_now, op_out;

    vecs.push_back(mk("6/2",          32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 4'b0000));
    vecs.push_back(mk("1/3",          32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 32'h3EAAAAAA, 4'b0000));
    vecs.push_back(mk("-6/2 raw hi",  32'hC0C00000, 32'h40000000, 32'hFFC00000, 32'hC0400000, 4'b0000));
    vecs.push_back(mk("1/0",          32'h3F800000, 32'h00000000, 32'h12345678, 32'h7F800000, 4'b0100));
    vecs.push_back(mk("-1/0",         32'hBF800000, 32'h00000000, 32'h00000000, 32'hFF800000, 4'b0100));
    vecs.push_back(mk("0/0",          32'h00000000, 32'h00000000, 32'h12345678, 32'h7FC00000, 4'b1000));
    vecs.push_back(mk("inf/-inf",     32'h7F800000, 32'hFF800000, 32'h00000000, 32'h7FC00000, 4'b1000));
    vecs.push_back(mk("nan/1",        32'h7F800001, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 4'b1000));
    vecs.push_back(mk("1/nan",        32'h3F800000, 32'hFFC00000, 32'h00000000, 32'h7FC00000, 4'b1000));
    vecs.push_back(mk("inf/2",        32'h7F800000, 32'h40000000, 32'h00000000, 32'h7F800000, 4'b0000));
    vecs.push_back(mk("-inf/0",       32'hFF800000, 32'h00000000, 32'h00000000, 32'hFF800000, 4'b0000));
    vecs.push_back(mk("0/5",          32'h00000000, 32'h40A00000, 32'h12345678, 32'h00000000, 4'b0000));
    vecs.push_back(mk("-2/inf",       32'hC0000000, 32'h7F800000, 32'h00000000, 32'h80000000, 4'b0000));
    vecs.push_back(mk("-0/inf",       32'h80000000, 32'h7F800000, 32'h00000000, 32'h80000000, 4'b0000));
    vecs.push_back(mk("denorm/1",     32'h00000001, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000));
    vecs.push_back(mk("1/-denorm",    32'h3F800000, 32'h807FFFFF, 32'h00000000, 32'hFF800000, 4'b0100));
    vecs.push_back(mk("ovf b=256",    32'h7F000000, 32'h3E800000, 32'h00000000, 32'h7F800000, 4'b0010));
    vecs.push_back(mk("ovf b=255",    32'h7F000000, 32'h3F000000, 32'h00000000, 32'h7F800000, 4'b0010));
    vecs.push_back(mk("max b=254",    32'h7F000000, 32'h3F800000, 32'h7F000000, 32'h7F000000, 4'b0000));
    vecs.push_back(mk("min b=1",      32'h00800000, 32'h3F800000, 32'h00800000, 32'h00800000, 4'b0000));
    vecs.push_back(mk("udf lt b=0",   32'h00800000, 32'h3FC00000, 32'h00000000, 32'h00000000, 4'b0001));
    vecs.push_back(mk("udf d=0",      32'h00800000, 32'h40000000, 32'h00000000, 32'h00000000, 4'b0001));
    vecs.push_back(mk("udf neg",      32'h80800000, 32'h7F000000, 32'h00000000, 32'h80000000, 4'b0001));
    vecs.push_back(mk("1.5/1.75",     32'h3FC00000, 32'h3FE00000, 32'h3F5B6DB6, 32'h3F5B6DB6, 4'b0000));

    rst = 1'b1;
    bus.clr_sticky = 1'b0;
    drive(1'b0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset res", bus.res, 32'd0);
    check("reset flags", 32'(flags_now()), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(i);

    // Back-to-back ops with a one-cycle gap after the third.
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      op_now = -1;
      op_out = -1;
      for (int j = 0; j < 5; j++) begin
        if (sched_cyc[j] == cyc)     op_now = sched_op[j];
        if (sched_cyc[j] == cyc - 3) op_out = sched_op[j];
      end
      if (op_now >= 0) drive(1'b1, vecs[op_now].v1, vecs[op_now].v2, vecs[op_now].raw);
      else             drive(1'b0, '0, '0, '0);
      @(posedge clk);
      #1;
      check($sformatf("b2b valid c%0d", cyc), 32'(bus.out_valid), 32'(op_out >= 0));
      if (op_out >= 0 && bus.out_valid) begin
        check({"b2b res ", vecs[op_out].name}, bus.res, vecs[op_out].exp_res);
        check({"b2b flags ", vecs[op_out].name}, 32'(flags_now()), 32'(vecs[op_out].exp_flags));
      end
    end

    // Reset with three ops in flight: none may emerge.
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      rst = (cyc == 3);
      if (cyc < 3) drive(1'b1, vecs[cyc].v1, vecs[cyc].v2, vecs[cyc].raw);
      else         drive(1'b0, '0, '0, '0);
      @(posedge clk);
      #1;
      check($sformatf("rst drain valid c%0d", cyc), 32'(bus.out_valid), 32'd0);
    end
    rst = 1'b0;
    run_vec(16);
    run_vec(0);

`ifdef FLOAT_DIV_FIXUP_STICKY_EN
    @(negedge clk);
    bus.clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_sticky = 1'b0;
    check("sticky cleared", 32'(bus.sticky_flags), 32'd0);
    run_vec(3);
    run_vec(0);
    check("sticky divzero kept", 32'(bus.sticky_flags), 32'b0100);
    @(negedge clk);
    bus.clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_sticky = 1'b0;
    check("sticky clr pulse", 32'(bus.sticky_flags), 32'd0);
    run_vec(5);
    check("sticky invalid", 32'(bus.sticky_flags), 32'b1000);
    // Clear lands on the same edge the overflow result loads.
    @(negedge clk);
    drive(1'b1, vecs[16].v1, vecs[16].v2, vecs[16].raw);
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (cyc > 0) @(negedge clk);
      bus.clr_sticky = (cyc == 3);
      @(posedge clk);
      #1;
      if (cyc == 0) drive(1'b0, '0, '0, '0);
    end
    bus.clr_sticky = 1'b0;
    check("sticky clr+ovf valid", 32'(bus.out_valid), 32'd1);
    check("sticky clr+ovf", 32'(bus.sticky_flags), 32'b0010);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
